// File: rtl/cache_axi_pkg.sv
// Shared types and constants for the cache read-path arbiter.
package cache_axi_pkg;

  // Who currently owns the downstream read path.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    ICACHE = 2'd1,
    DCACHE = 2'd2
  } owner_t;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  // Read request size encodings carried on *_r_type.
  localparam logic [2:0] R_TYPE_B    = 3'd0;
  localparam logic [2:0] R_TYPE_H    = 3'd1;
  localparam logic [2:0] R_TYPE_W    = 3'd2;
  localparam logic [2:0] R_TYPE_LINE = 3'd4;

endpackage

// File: rtl/cache_rd_arbiter_rr_arb2.sv
// Two-way requester pick: bit 0 = icache, bit 1 = dcache. Grant is one-hot or zero.
module rr_arb2
  import cache_axi_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output logic [1:0] grant
);

  // A lone requester always wins; a tie goes to dcache under fixed priority,
  // otherwise to whichever side was not served last.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b01) begin
      grant = 2'b01;
    end else if (req == 2'b10) begin
      grant = 2'b10;
    end else if (req == 2'b11) begin
      if ((FIXED_PRIO != 0) || (last_owner != DCACHE)) begin
        grant = 2'b10;
      end else begin
        grant = 2'b01;
      end
    end
  end

endmodule

// File: rtl/cache_rd_arbiter.sv
// Shares one AXI read request/return path between the icache and dcache refill engines.
// Handshake: a requester holds *_r_req until its *_r_rdy pulse; *_r_rdy is the bridge's
// m_r_rdy steered to the latched owner while in REQ. A return beat moves only in a cycle
// where m_ret_valid and m_r_data_ready are both high; the grant is held until the beat
// carrying m_ret_last moves.
module cache_rd_arbiter
  import cache_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  // icache side
  input  logic                  i_r_req,
  input  logic [ADDR_WIDTH-1:0] i_r_addr,
  output logic                  i_r_rdy,
  output logic                  i_ret_valid,
  output logic                  i_ret_last,
  output logic [DATA_WIDTH-1:0] i_r_data,
  input  logic                  i_r_data_ready,
  // dcache side
  input  logic                  d_r_req,
  input  logic [ADDR_WIDTH-1:0] d_r_addr,
  input  logic [2:0]            d_r_type,
  output logic                  d_r_rdy,
  output logic                  d_ret_valid,
  output logic                  d_ret_last,
  output logic [DATA_WIDTH-1:0] d_r_data,
  input  logic                  d_r_data_ready,
  // AXI bridge side
  output logic                  m_r_req,
  output logic [ADDR_WIDTH-1:0] m_r_addr,
  output logic [2:0]            m_r_type,
  input  logic                  m_r_rdy,
  input  logic                  m_ret_valid,
  input  logic                  m_ret_last,
  input  logic [DATA_WIDTH-1:0] m_r_data,
  output logic                  m_r_data_ready,
  // status
  output logic                  busy,
  output arb_state_t            state_dbg
);

  arb_state_t            state;
  owner_t                owner;
  owner_t                last_owner;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            type_q;
  logic                  m_r_req_q;
  logic [1:0]            grant;

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_pick (
    .req       ({d_r_req, i_r_req}),
    .last_owner(last_owner),
    .grant     (grant)
  );

  // Arbitration FSM: latch the winner in IDLE, present it in REQ, stream its beats in DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= NONE;
      last_owner <= ICACHE;
      addr_q     <= '0;
      type_q     <= '0;
      m_r_req_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant[1]) begin
            owner     <= DCACHE;
            addr_q    <= d_r_addr;
            type_q    <= d_r_type;
            m_r_req_q <= 1'b1;
            state     <= REQ;
          end else if (grant[0]) begin
            owner     <= ICACHE;
            addr_q    <= i_r_addr;
            type_q    <= R_TYPE_LINE;
            m_r_req_q <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          // Requesters dropping req here do not matter: the latched request completes.
          if (m_r_rdy) begin
            last_owner <= owner;
            m_r_req_q  <= 1'b0;
            state      <= DATA;
          end
        end
        DATA: begin
          if (m_ret_valid && m_r_data_ready && m_ret_last) begin
            owner <= NONE;
            state <= IDLE;
          end
        end
        default: begin
          owner     <= NONE;
          m_r_req_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign m_r_req   = m_r_req_q;
  assign m_r_addr  = addr_q;
  assign m_r_type  = type_q;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Steer the accept pulse and return beats to the owner only; beats outside DATA are dropped.
  always_comb begin
    i_r_rdy        = (state == REQ) && (owner == ICACHE) && m_r_rdy;
    d_r_rdy        = (state == REQ) && (owner == DCACHE) && m_r_rdy;
    i_ret_valid    = 1'b0;
    i_ret_last     = 1'b0;
    i_r_data       = '0;
    d_ret_valid    = 1'b0;
    d_ret_last     = 1'b0;
    d_r_data       = '0;
    m_r_data_ready = 1'b0;
    if (state == DATA) begin
      if (owner == ICACHE) begin
        i_ret_valid    = m_ret_valid;
        i_ret_last     = m_ret_last;
        i_r_data       = m_r_data;
        m_r_data_ready = i_r_data_ready;
      end else if (owner == DCACHE) begin
        d_ret_valid    = m_ret_valid;
        d_ret_last     = m_ret_last;
        d_r_data       = m_r_data;
        m_r_data_ready = d_r_data_ready;
      end
    end
  end

endmodule
